// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: 4-channel round-robin arbiter with registered mux output.
// Optional burst lock enabled by defining RR_SEL_LOCK_EN.
module rr_sel_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [1:0]   sel,
    output logic [W-1:0] y,
    output logic         out_valid,
`ifdef RR_SEL_LOCK_EN
    input  logic         out_ready,
    input  logic         lock
`else
    input  logic         out_ready
`endif
);

    logic [1:0]   ptr;
    logic         load;
    logic         any;
    logic [3:0]   rot;
    logic [1:0]   off;
    logic [1:0]   gidx;
    logic [3:0]   gnt;
    logic [W-1:0] gdata;
    logic [1:0]   nptr;

    assign load = !out_valid || out_ready;
    assign any  = |req_valid;

    // Rotate so that bit 0 is the channel at ptr.
    always_comb begin
        rot = req_valid;
        unique case (ptr)
            2'd0: rot = req_valid;
            2'd1: rot = {req_valid[0], req_valid[3:1]};
            2'd2: rot = {req_valid[1:0], req_valid[3:2]};
            2'd3: rot = {req_valid[2:0], req_valid[3]};
        endcase
    end

    always_comb begin
        off = 2'd0;
        priority case (1'b1)
            rot[0]:  off = 2'd0;
            rot[1]:  off = 2'd1;
            rot[2]:  off = 2'd2;
            rot[3]:  off = 2'd3;
            default: off = 2'd0;
        endcase
    end

    assign gidx = ptr + off;

    always_comb begin
        gnt = 4'b0000;
        if (rst_n && load && any)
            gnt = 4'b0001 << gidx;
    end

    assign req_ready = gnt;

    // Only the granted channel is routed; idle lanes never reach y.
    always_comb begin
        gdata = '0;
        unique case (1'b1)
            gnt[0]:  gdata = d0;
            gnt[1]:  gdata = d1;
            gnt[2]:  gdata = d2;
            gnt[3]:  gdata = d3;
            default: gdata = '0;
        endcase
    end

`ifdef RR_SEL_LOCK_EN
    assign nptr = lock ? gidx : gidx + 2'd1;
`else
    assign nptr = gidx + 2'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 2'd0;
            y         <= '0;
            sel       <= 2'd0;
            out_valid <= 1'b0;
        end else if (load) begin
            if (any) begin
                y         <= gdata;
                sel       <= gidx;
                out_valid <= 1'b1;
                ptr       <= nptr;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed and randomized checks of rr_sel_arbiter
// against a queue-free behavioural round-robin model.
module tb_rr_sel_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = 4'b0;
    logic [3:0]   req_ready;
    logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         lock = 1'b0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_y;
    int           m_sel;
    logic [3:0]   e_rdy;
    int           e_g;

    rr_sel_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .sel(sel), .y(y), .out_valid(out_valid),
`ifdef RR_SEL_LOCK_EN
        .out_ready(out_ready), .lock(lock)
`else
        .out_ready(out_ready)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] chan_data(input int g);
        case (g)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    function automatic bit lock_eff();
`ifdef RR_SEL_LOCK_EN
        return lock;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_valid = 0; m_y = '0; m_sel = 0;
    endfunction

    // Scan channels starting at the priority pointer, wrapping mod 4.
    function automatic void model_grant();
        e_g = -1;
        e_rdy = 4'b0;
        if (!m_valid || out_ready)
            for (int k = 0; k < 4; k++)
                if (e_g < 0 && req_valid[(m_ptr + k) % 4])
                    e_g = (m_ptr + k) % 4;
        if (e_g >= 0) e_rdy[e_g] = 1'b1;
    endfunction

    function automatic void model_commit();
        if (!m_valid || out_ready) begin
            if (e_g >= 0) begin
                m_y = chan_data(e_g);
                m_sel = e_g;
                m_valid = 1;
                m_ptr = lock_eff() ? e_g : (e_g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b0; out_ready = 1'b0; lock = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b0; out_ready = 1'b1;
        model_reset();
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (y !== '0) $display("FAIL reset_y got %h want 0", y);
        else pass_cnt++;
        chk_cnt++;
        if (sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", sel);
        else pass_cnt++;
        chk_cnt++;
        if (req_ready !== 4'b0) $display("FAIL reset_rdy got %b want 0000", req_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_channels();
        apply_reset();
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b1111; out_ready = 1'b1;
            #1;
            model_grant();
            chk_cnt++;
            if (req_ready !== e_rdy) $display("FAIL all_rdy got %b want %b", req_ready, e_rdy);
            else pass_cnt++;
            @(posedge clk); #1;
            model_commit();
            chk_cnt++;
            if (sel !== 2'(i % 4) || y !== m_y || out_valid !== 1'b1)
                $display("FAIL all_beat got sel=%0d y=%h v=%b want sel=%0d y=%h v=1",
                         sel, y, out_valid, i % 4, m_y);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_sparse();
        apply_reset();
        d0 = 4'h0; d1 = 4'd10; d2 = 4'h0; d3 = 'x;
        for (int i = 0; i < 6; i++) begin
            req_valid = (i < 4) ? 4'b1010 : 4'b0010;
            out_ready = 1'b1;
            #1;
            model_grant();
            @(posedge clk); #1;
            model_commit();
            chk_cnt++;
            if (sel !== 2'(m_sel) || y !== m_y)
                $display("FAIL sparse got sel=%0d y=%h want sel=%0d y=%h", sel, y, m_sel, m_y);
            else pass_cnt++;
            if (i >= 4) begin
                chk_cnt++;
                if (y !== 4'd10) $display("FAIL sparse_single got y=%h want a", y);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        d3 = 4'h0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        req_valid = 4'b1111; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++;
            if (req_ready !== 4'b0) $display("FAIL bp_rdy got %b want 0000", req_ready);
            else pass_cnt++;
            @(posedge clk); #1;
            chk_cnt++;
            if (y !== 4'hc || sel !== 2'd2 || out_valid !== 1'b1)
                $display("FAIL bp_hold got y=%h sel=%0d v=%b want y=c sel=2 v=1", y, sel, out_valid);
            else pass_cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL bp_release_rdy got %b want 1000", req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (sel !== 2'd3 || y !== 4'hd) $display("FAIL bp_release got sel=%0d y=%h want sel=3 y=d", sel, y);
        else pass_cnt++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            lock = ($urandom_range(0, 3) == 0);
            d0 = 4'($urandom); d1 = 4'($urandom);
            d2 = 4'($urandom); d3 = 4'($urandom);
            #1;
            model_grant();
            chk_cnt++;
            if (req_ready !== e_rdy)
                $display("FAIL rand_rdy cyc %0d got %b want %b", i, req_ready, e_rdy);
            else pass_cnt++;
            @(posedge clk); #1;
            model_commit();
            chk_cnt++;
            if (out_valid !== m_valid || (m_valid && (y !== m_y || sel !== 2'(m_sel))))
                $display("FAIL rand_out cyc %0d got v=%b y=%h sel=%0d want v=%b y=%h sel=%0d",
                         i, out_valid, y, sel, m_valid, m_y, m_sel);
            else pass_cnt++;
            @(negedge clk);
        end
        lock = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        req_valid = 4'b1111; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || y !== '0 || sel !== 2'd0 || req_ready !== 4'b0)
            $display("FAIL midrst got v=%b y=%h sel=%0d rdy=%b want all zero",
                     out_valid, y, sel, req_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL midrst_rdy got %b want 0001", req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (sel !== 2'd0 || y !== 4'h1 || out_valid !== 1'b1)
            $display("FAIL midrst_first got sel=%0d y=%h v=%b want sel=0 y=1 v=1", sel, y, out_valid);
        else pass_cnt++;
        @(negedge clk);
    endtask

`ifdef RR_SEL_LOCK_EN
    task automatic test_lock();
        int exp_sel[6] = '{0, 1, 2, 2, 2, 3};
        apply_reset();
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b1111; out_ready = 1'b1;
            lock = (i == 2 || i == 3);
            #1;
            model_grant();
            @(posedge clk); #1;
            model_commit();
            chk_cnt++;
            if (sel !== 2'(exp_sel[i]) || sel !== 2'(m_sel))
                $display("FAIL lock cyc %0d got sel=%0d want %0d", i, sel, exp_sel[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        lock = 1'b0;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_all_channels();
        test_sparse();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef RR_SEL_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
